// File: rtl/fifo_wr_arbiter.sv
// fifo_wr_arbiter: round-robin burst arbiter sharing one fifo write port between two producers
// Bursts are capped at BURST words (1 while PFF) and any grant is dropped on FF or a withdrawn request.
module fifo_wr_arbiter #(
  parameter int WIDTH = 8,
  parameter int BURST = 4,
  parameter int CNTW  = 16
) (
  input  logic             clk,
  input  logic             RESET,
  input  logic             REQ0,
  input  logic [WIDTH-1:0] DIN0,
  output logic             ACK0,
  input  logic             REQ1,
  input  logic [WIDTH-1:0] DIN1,
  output logic             ACK1,
  input  logic             FF,
  input  logic             PFF,
  output logic             WE,
  output logic [WIDTH-1:0] DATA_IN,
  output logic [1:0]       GNT,
  output logic [CNTW-1:0]  WCNT0,
  output logic [CNTW-1:0]  WCNT1
);
  localparam int BW = $clog2(BURST + 1);
  typedef enum logic [1:0] {IDLE, SERVE0, SERVE1} state_t;
  state_t          r_state;
  logic            r_rr;
  logic [BW-1:0]   r_bcnt;
  logic [CNTW-1:0] r_wcnt0, r_wcnt1;
  logic            w_s0, w_s1, w_req, w_we, w_end, w_oreq, w_pick1;
  logic [BW-1:0]   w_lim;
  state_t          w_other;
  assign w_s0    = r_state == SERVE0;
  assign w_s1    = r_state == SERVE1;
  assign w_req   = w_s0 ? REQ0 : (w_s1 & REQ1);
  assign w_we    = w_req & ~FF & ~RESET;
  assign w_lim   = PFF ? BW'(1) : BW'(BURST);
  assign w_end   = (w_we & (r_bcnt + BW'(1) >= w_lim)) | ~w_req | FF;
  assign w_oreq  = w_s0 ? REQ1 : REQ0;
  assign w_other = w_s0 ? SERVE1 : SERVE0;
  // r_rr=1 means producer 1 wins a tie
  assign w_pick1 = REQ1 & (~REQ0 | r_rr);
  assign WE      = w_we;
  assign ACK0    = w_we & w_s0;
  assign ACK1    = w_we & w_s1;
  assign DATA_IN = w_we ? (w_s0 ? DIN0 : DIN1) : '0;
  assign GNT     = {w_s1, w_s0};
  assign WCNT0   = r_wcnt0;
  assign WCNT1   = r_wcnt1;
  always_ff @(posedge clk) begin
    if (RESET) begin
      r_state <= IDLE;
      r_rr    <= 1'b0;
      r_bcnt  <= '0;
      r_wcnt0 <= '0;
      r_wcnt1 <= '0;
    end else begin
      if (ACK0 && !(&r_wcnt0)) r_wcnt0 <= r_wcnt0 + CNTW'(1);
      if (ACK1 && !(&r_wcnt1)) r_wcnt1 <= r_wcnt1 + CNTW'(1);
      if (r_state == IDLE) begin
        r_bcnt <= '0;
        if (!FF && (REQ0 || REQ1)) r_state <= w_pick1 ? SERVE1 : SERVE0;
      end else if (w_end) begin
        r_state <= (w_oreq && !FF) ? w_other : IDLE;
        r_rr    <= w_s0;
        r_bcnt  <= '0;
      end else begin
        r_bcnt  <= r_bcnt + BW'(1);
      end
    end
  end
endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// tb_fifo_wr_arbiter: directed scenarios plus random traffic against a grant-level reference model
module tb_fifo_wr_arbiter;
  localparam int WIDTH = 8;
  localparam int BURST = 4;
  localparam int CNTW  = 4;
  localparam int CMAX  = (1 << CNTW) - 1;
  logic             clk = 1'b0;
  logic             rst = 1'b1;
  logic             req0 = 1'b0, req1 = 1'b0, ff = 1'b0, pff = 1'b0;
  logic [WIDTH-1:0] din0 = '0, din1 = '0;
  logic             ack0, ack1, we;
  logic [WIDTH-1:0] data_in;
  logic [1:0]       gnt;
  logic [CNTW-1:0]  wcnt0, wcnt1;
  int               n_chk = 0, n_pass = 0;
  int               m_own, m_words, m_pref;
  int               m_cnt [2];
  logic [7:0]       lfsr = 8'h5a;

  fifo_wr_arbiter #(.WIDTH(WIDTH), .BURST(BURST), .CNTW(CNTW)) dut (
    .clk(clk), .RESET(rst),
    .REQ0(req0), .DIN0(din0), .ACK0(ack0),
    .REQ1(req1), .DIN1(din1), .ACK1(ack1),
    .FF(ff), .PFF(pff), .WE(we), .DATA_IN(data_in), .GNT(gnt),
    .WCNT0(wcnt0), .WCNT1(wcnt1)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask

  function automatic logic rq(input int k);
    return k == 1 ? req1 : req0;
  endfunction

  // Checks the outputs for the inputs now applied, then advances the model past one posedge.
  task automatic step;
    logic e_we;
    int   o;
    #1;
    e_we = !rst && m_own >= 0 && rq(m_own) && !ff;
    chk("we", we, e_we);
    chk("gnt", gnt, m_own < 0 ? 0 : (1 << m_own));
    chk("ack0", ack0, e_we && m_own == 0);
    chk("ack1", ack1, e_we && m_own == 1);
    chk("data", data_in, !e_we ? 0 : (m_own == 1 ? din1 : din0));
    chk("wcnt0", wcnt0, m_cnt[0]);
    chk("wcnt1", wcnt1, m_cnt[1]);
    if (rst) begin
      m_own = -1; m_words = 0; m_pref = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    end else if (m_own < 0) begin
      if (!ff && (req0 || req1)) begin
        m_own = (req0 && req1) ? m_pref : (req1 ? 1 : 0);
        m_words = 0;
      end
    end else begin
      if (e_we) begin
        if (m_cnt[m_own] < CMAX) m_cnt[m_own]++;
        m_words++;
      end
      if ((e_we && m_words >= (pff ? 1 : BURST)) || !rq(m_own) || ff) begin
        o = 1 - m_own;
        m_pref = o;
        m_own = (rq(o) && !ff) ? o : -1;
        m_words = 0;
      end
    end
    @(negedge clk);
  endtask

  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      lfsr = {lfsr[6:0], lfsr[7] ^ lfsr[5] ^ lfsr[4] ^ lfsr[3]};
      din0 = lfsr;
      din1 = 8'($urandom);
      step();
    end
  endtask

  initial begin
    m_own = -1; m_words = 0; m_pref = 0; m_cnt[0] = 0; m_cnt[1] = 0;
    req0 = 1'b1; req1 = 1'b1;
    @(posedge clk); @(negedge clk);
    run(2);
    rst = 1'b0; req1 = 1'b0;
    run(10);
    req0 = 1'b0;
    chk("wcnt0_after_10", wcnt0, 8);
    run(2);
    req0 = 1'b1; req1 = 1'b1;
    run(17);
    req0 = 1'b0; req1 = 1'b0;
    run(2);
    req0 = 1'b1; req1 = 1'b1; pff = 1'b1;
    run(9);
    pff = 1'b0;
    run(3);
    ff = 1'b1;
    run(3);
    ff = 1'b0;
    run(6);
    for (int i = 0; i < 20 && m_own != 1; i++) run(1);
    chk("reached_serve1", m_own, 1);
    rst = 1'b1;
    run(1);
    rst = 1'b0;
    chk("gnt_after_rst", gnt, 0);
    chk("wcnt1_after_rst", wcnt1, 0);
    run(2);
    for (int i = 0; i < 3000; i++) begin
      req0 = $urandom_range(3) != 0;
      req1 = $urandom_range(3) != 0;
      ff   = $urandom_range(6) == 0;
      pff  = $urandom_range(3) == 0;
      rst  = $urandom_range(99) == 0;
      run(1);
    end
    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end
endmodule
